walsh_inverse: RTL

- Inverse 8-point Walsh-Hadamard transform; the receive-side counterpart of the pipelined forward transform.
- Takes 8 signed coefficients and recovers the 8 original 1-bit samples.
- Elastic valid/ready pipeline: 3 butterfly stages, then a decode/check stage.
- Flags coefficient vectors that do not decode to a legal bit pattern and keeps a saturating error count.

---
 rtl/walsh_pkg.sv | 14 +
 rtl/walsh_inverse_if.sv | 28 ++
 rtl/walsh_bfly.sv | 19 +
 rtl/walsh_inverse.sv | 128 ++++++++++++
 4 files changed

// File: rtl/walsh_pkg.sv
// Shared constants for the 8-point Walsh-Hadamard forward and inverse blocks.
// N_PTS     : transform size (fixed at 8, three radix-2 butterfly stages)
// W_IN_DEF  : default signed coefficient width
// CNT_W_DEF : default width of the saturating error counter
// stage_w() : width of butterfly stage s (each stage grows by one bit)
package walsh_pkg;
  localparam int N_PTS     = 8;
  localparam int W_IN_DEF  = 5;
  localparam int CNT_W_DEF = 8;

  function automatic int stage_w(input int w_in, input int stage);
    return w_in + stage;
  endfunction
endpackage

// File: rtl/walsh_inverse_if.sv
// Valid/ready bundle for the inverse Walsh transform.
// Request side : c0..c7 (signed coefficients), in_valid, in_ready
// Response side: b0..b7 (recovered bits), err, out_valid, out_ready
// master = the block driving coefficients and consuming results;
// slave  = the transform itself.
interface walsh_inverse_if
  import walsh_pkg::*;
#(
  parameter int W_IN = W_IN_DEF
) ();
  logic signed [W_IN-1:0] c0, c1, c2, c3, c4, c5, c6, c7;
  logic                   in_valid;
  logic                   in_ready;
  logic                   b0, b1, b2, b3, b4, b5, b6, b7;
  logic                   err;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output c0, c1, c2, c3, c4, c5, c6, c7, in_valid, out_ready,
    input  in_ready, b0, b1, b2, b3, b4, b5, b6, b7, err, out_valid
  );

  modport slave (
    input  c0, c1, c2, c3, c4, c5, c6, c7, in_valid, out_ready,
    output in_ready, b0, b1, b2, b3, b4, b5, b6, b7, err, out_valid
  );
endinterface

// File: rtl/walsh_bfly.sv
// Radix-2 Walsh butterfly: sum = a + b, diff = a - b.
// Ports: a, b (signed, W bits) -> sum, diff (signed, W+1 bits).
// Operands are sign-extended by one bit first so neither result can overflow.
module walsh_bfly #(
  parameter int W = 5
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W:0]   sum,
  output logic signed [W:0]   diff
);
  logic signed [W:0] a_x;
  logic signed [W:0] b_x;

  assign a_x  = {a[W-1], a};
  assign b_x  = {b[W-1], b};
  assign sum  = a_x + b_x;
  assign diff = a_x - b_x;
endmodule

// File: rtl/walsh_inverse.sv
// Inverse 8-point Walsh-Hadamard transform with valid/ready flow control.
// Three butterfly stages rebuild 8*x_i from the coefficients; a decode stage
// turns each value back into a bit and flags vectors that are not 0 or 8.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : c0..c7/in_valid/in_ready in, b0..b7/err/out_valid/out_ready out
//   err_count    : saturating count of error beats handed downstream
// Flow control is a single global enable: the whole pipe advances together
// or holds together, so bubbles are carried along rather than squeezed out.
module walsh_inverse
  import walsh_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  walsh_inverse_if.slave   bus,
  output logic [CNT_W-1:0] err_count
);
  localparam int W1 = stage_w(W_IN, 1);
  localparam int W2 = stage_w(W_IN, 2);
  localparam int W3 = stage_w(W_IN, 3);
  // A legal sample bit reconstructs to exactly 0 or 8.
  localparam logic signed [W3-1:0] T3_ONE = W3'(8);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic en;
  logic signed [W_IN-1:0] c_p0  [N_PTS];
  logic signed [W1-1:0]   s1    [N_PTS];
  logic signed [W1-1:0]   t1_p1 [N_PTS];
  logic signed [W2-1:0]   s2    [N_PTS];
  logic signed [W2-1:0]   t2_p2 [N_PTS];
  logic signed [W3-1:0]   s3    [N_PTS];
  logic signed [W3-1:0]   t3_p3 [N_PTS];
  logic                   vld_p1, vld_p2, vld_p3, vld_p4;
  logic [N_PTS-1:0]       b_dec, b_p4;
  logic                   err_dec, err_p4;

  assign en           = !vld_p4 || bus.out_ready;
  assign bus.in_ready = en;

  assign c_p0[0] = bus.c0;
  assign c_p0[1] = bus.c1;
  assign c_p0[2] = bus.c2;
  assign c_p0[3] = bus.c3;
  assign c_p0[4] = bus.c4;
  assign c_p0[5] = bus.c5;
  assign c_p0[6] = bus.c6;
  assign c_p0[7] = bus.c7;

  // ---- stage 1: butterflies at distance 4 ----
  for (genvar k = 0; k < N_PTS / 2; k++) begin : g_s1
    walsh_bfly #(.W(W_IN)) u_bfly (
      .a(c_p0[k]), .b(c_p0[k+4]), .sum(s1[k]), .diff(s1[k+4])
    );
  end

  // ---- stage 2: butterflies at distance 2 within each half ----
  for (genvar j = 0; j < N_PTS / 2; j++) begin : g_s2
    localparam int K = (j / 2) * 4 + (j % 2);
    walsh_bfly #(.W(W1)) u_bfly (
      .a(t1_p1[K]), .b(t1_p1[K+2]), .sum(s2[K]), .diff(s2[K+2])
    );
  end

  // ---- stage 3: butterflies at distance 1 ----
  for (genvar j = 0; j < N_PTS / 2; j++) begin : g_s3
    localparam int K = 2 * j;
    walsh_bfly #(.W(W2)) u_bfly (
      .a(t2_p2[K]), .b(t2_p2[K+1]), .sum(s3[K]), .diff(s3[K+1])
    );
  end

  // ---- decode: bit 3 of 8*x_i is x_i; anything but 0/8 is illegal ----
  always_comb begin
    b_dec   = '0;
    err_dec = 1'b0;
    for (int i = 0; i < N_PTS; i++) begin
      b_dec[i] = t3_p3[i][3];
      if (t3_p3[i] != '0 && t3_p3[i] != T3_ONE) err_dec = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (en) begin
      t1_p1 <= s1;
      t2_p2 <= s2;
      t3_p3 <= s3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      vld_p4    <= 1'b0;
      b_p4      <= '0;
      err_p4    <= 1'b0;
      err_count <= '0;
    end else begin
      if (en) begin
        vld_p1 <= bus.in_valid;
        vld_p2 <= vld_p1;
        vld_p3 <= vld_p2;
        vld_p4 <= vld_p3;
        b_p4   <= b_dec;
        err_p4 <= err_dec;
      end
      if (vld_p4 && bus.out_ready && err_p4) err_count <= sat_inc(err_count);
    end
  end

  assign bus.out_valid = vld_p4;
  assign bus.err       = err_p4;
  assign bus.b0        = b_p4[0];
  assign bus.b1        = b_p4[1];
  assign bus.b2        = b_p4[2];
  assign bus.b3        = b_p4[3];
  assign bus.b4        = b_p4[4];
  assign bus.b5        = b_p4[5];
  assign bus.b6        = b_p4[6];
  assign bus.b7        = b_p4[7];
endmodule
